// File: rtl/branch_predictor_btb_pkg.sv
// branch_predictor_btb_pkg: default sizes and addressing constants for the BTB
package branch_predictor_btb_pkg;
    localparam int XLEN_DEF    = 32;
    localparam int ENTRIES_DEF = 16;
    localparam int CTR_W_DEF   = 2;
    localparam int STAT_W_DEF  = 32;
    localparam int WORD_OFF    = 2;
endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// sat_counter: saturating up/down counter with load, one per BTB entry
module sat_counter #(
    parameter int W = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt
);
    // load wins over inc/dec; inc and dec stop at the rails
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= RST_VAL;
        else if (load) cnt <= load_val;
        else if (inc && !(&cnt)) cnt <= cnt + W'(1);
        else if (dec && (|cnt)) cnt <= cnt - W'(1);
endmodule

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB with direction counters, redirect and stats
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int CTR_W   = CTR_W_DEF,
    parameter int STAT_W  = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [XLEN-1:0]   upd_pred_target,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    input  logic              stat_clear,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - WORD_OFF;
    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(1 << (CTR_W - 1));

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [XLEN-1:0]    targets [ENTRIES];
    logic [CTR_W-1:0]   ctrs    [ENTRIES];
    logic [IDX_W-1:0]   l_idx, u_idx;
    logic [TAG_W-1:0]   l_tag, u_tag;
    logic               u_hit;

    assign l_idx = lookup_pc[IDX_W+WORD_OFF-1:WORD_OFF];
    assign l_tag = lookup_pc[XLEN-1:IDX_W+WORD_OFF];
    assign u_idx = upd_pc[IDX_W+WORD_OFF-1:WORD_OFF];
    assign u_tag = upd_pc[XLEN-1:IDX_W+WORD_OFF];
    assign u_hit = valid[u_idx] && tags[u_idx] == u_tag;

    assign pred_hit    = valid[l_idx] && tags[l_idx] == l_tag;
    assign pred_taken  = pred_hit && ctrs[l_idx][CTR_W-1];
    assign pred_target = pred_taken ? targets[l_idx] : lookup_pc + XLEN'(4);

    assign mispredict  = upd_valid && (upd_taken != upd_pred_taken ||
                                       (upd_taken && upd_target != upd_pred_target));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        logic wr;
        assign wr = upd_valid && u_idx == IDX_W'(i);
        sat_counter #(.W(CTR_W), .RST_VAL(WEAK_NT)) u_ctr (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (wr && u_hit && upd_taken),
            .dec      (wr && u_hit && !upd_taken),
            .load     (wr && !u_hit && upd_taken),
            .load_val (WEAK_T),
            .cnt      (ctrs[i])
        );
    end

    // allocation on a taken miss marks the entry valid
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) valid <= '0;
        else if (upd_valid && upd_taken && !u_hit) valid[u_idx] <= 1'b1;

    // tag/target storage is unreset; rst_n gating keeps a reset edge from writing it
    always_ff @(posedge clk)
        if (rst_n && upd_valid && upd_taken) begin
            targets[u_idx] <= upd_target;
            if (!u_hit) tags[u_idx] <= u_tag;
        end

    // statistics: clear beats increment, both stick at all-ones
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (stat_clear) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_valid && !(&stat_branches)) stat_branches <= stat_branches + STAT_W'(1);
            if (mispredict && !(&stat_mispredicts)) stat_mispredicts <= stat_mispredicts + STAT_W'(1);
        end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: directed table, corner sequences and randomized model check
module tb_branch_predictor_btb;
    localparam int ENT  = 16;
    localparam int SMAX = 15;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] lookup_pc = 0;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 0;
    logic [31:0] upd_pc = 0;
    logic        upd_taken = 0;
    logic [31:0] upd_target = 0;
    logic        upd_pred_taken = 0;
    logic [31:0] upd_pred_target = 0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        stat_clear = 0;
    logic [3:0]  stat_branches, stat_mispredicts;

    int checks = 0;
    int errors = 0;

    branch_predictor_btb #(.XLEN(32), .ENTRIES(ENT), .CTR_W(2), .STAT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .stat_clear(stat_clear),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: a plain direct-mapped table indexed by word address modulo depth
    bit          m_valid [ENT];
    int unsigned m_tag   [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_ctr   [ENT];
    int          m_br, m_ms;

    function automatic int unsigned ix(input logic [31:0] pc);
        return (pc / 4) % ENT;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[ix(pc)] && m_tag[ix(pc)] == pc / (4 * ENT);
    endfunction

    function automatic bit m_misp();
        if (!upd_valid) return 0;
        if (upd_taken != upd_pred_taken) return 1;
        return upd_taken && upd_target != upd_pred_target;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0;
            m_ctr[i] = 1;
        end
        m_br = 0;
        m_ms = 0;
    endtask

    // apply the model's view of one clock edge using the current inputs
    task automatic m_edge();
        int unsigned i;
        bit mp;
        mp = m_misp();
        i = ix(upd_pc);
        if (stat_clear) begin
            m_br = 0;
            m_ms = 0;
        end else begin
            if (upd_valid && m_br < SMAX) m_br++;
            if (mp && m_ms < SMAX) m_ms++;
        end
        if (upd_valid) begin
            if (m_hit(upd_pc)) begin
                if (upd_taken) begin
                    m_ctr[i] = m_ctr[i] < 3 ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = upd_target;
                end else m_ctr[i] = m_ctr[i] > 0 ? m_ctr[i] - 1 : 0;
            end else if (upd_taken) begin
                m_valid[i] = 1;
                m_tag[i] = upd_pc / (4 * ENT);
                m_tgt[i] = upd_target;
                m_ctr[i] = 2;
            end
        end
    endtask

    task automatic model_check(input string tag);
        bit e_hit, e_tk;
        e_hit = m_hit(lookup_pc);
        e_tk = e_hit && m_ctr[ix(lookup_pc)] >= 2;
        chk({tag, ".hit"}, 32'(pred_hit), 32'(e_hit));
        chk({tag, ".taken"}, 32'(pred_taken), 32'(e_tk));
        chk({tag, ".target"}, pred_target, e_tk ? m_tgt[ix(lookup_pc)] : lookup_pc + 32'd4);
        chk({tag, ".misp"}, 32'(mispredict), 32'(m_misp()));
        if (m_misp()) chk({tag, ".redirect"}, redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
        chk({tag, ".br"}, 32'(stat_branches), 32'(m_br));
        chk({tag, ".ms"}, 32'(stat_mispredicts), 32'(m_ms));
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic t,
                           input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
        upd_valid = v;
        upd_pc = pc;
        upd_taken = t;
        upd_target = tg;
        upd_pred_taken = pt;
        upd_pred_target = ptg;
    endtask

    task automatic do_reset();
        rst_n = 0;
        stat_clear = 0;
        set_upd(0, 0, 0, 0, 0, 0);
        m_reset();
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    typedef struct {
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        upt;
        logic [31:0] uptg;
        logic        hit;
        logic        tk;
        logic [31:0] tgt;
        logic        mp;
        logic [31:0] rd;
        int          br;
        int          ms;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // lookup pc | update pc, taken, target, pred taken, pred target | expected hit, taken, target, misp, redirect, stats
        tbl[0]  = '{32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 32'h44,  0, 32'h0,   0, 0};
        tbl[1]  = '{32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 0, 32'h44,  1, 32'h100, 0, 0};
        tbl[2]  = '{32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 1, 32'h100, 0, 32'h0,   1, 1};
        tbl[3]  = '{32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 1, 1, 32'h100, 1, 32'h44,  1, 1};
        tbl[4]  = '{32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 0, 32'h44,  0, 32'h0,   2, 2};
        tbl[5]  = '{32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h44,  1, 0, 32'h44,  0, 32'h0,   2, 2};
        tbl[6]  = '{32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h44,  1, 0, 32'h44,  0, 32'h0,   3, 2};
        tbl[7]  = '{32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  1, 0, 32'h44,  1, 32'h100, 4, 2};
        tbl[8]  = '{32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 0, 32'h44,  0, 32'h0,   5, 3};
        tbl[9]  = '{32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 32'h84,  0, 32'h0,   5, 3};
        tbl[10] = '{32'h80, 1, 32'h80, 1, 32'h200, 0, 32'h84,  0, 0, 32'h84,  1, 32'h200, 5, 3};
        tbl[11] = '{32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 32'h44,  0, 32'h0,   6, 4};
        tbl[12] = '{32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 1, 32'h200, 0, 32'h0,   6, 4};

        do_reset();
        foreach (tbl[k]) begin
            lookup_pc = tbl[k].lpc;
            set_upd(tbl[k].uv, tbl[k].upc, tbl[k].ut, tbl[k].utg, tbl[k].upt, tbl[k].uptg);
            #1;
            chk($sformatf("v%0d.hit", k), 32'(pred_hit), 32'(tbl[k].hit));
            chk($sformatf("v%0d.taken", k), 32'(pred_taken), 32'(tbl[k].tk));
            chk($sformatf("v%0d.target", k), pred_target, tbl[k].tgt);
            chk($sformatf("v%0d.misp", k), 32'(mispredict), 32'(tbl[k].mp));
            if (tbl[k].mp) chk($sformatf("v%0d.redirect", k), redirect_pc, tbl[k].rd);
            chk($sformatf("v%0d.br", k), 32'(stat_branches), 32'(tbl[k].br));
            chk($sformatf("v%0d.ms", k), 32'(stat_mispredicts), 32'(tbl[k].ms));
            @(posedge clk);
            #1;
        end

        // same-cycle update and lookup from an empty table
        do_reset();
        lookup_pc = 32'h40;
        set_upd(1, 32'h40, 1, 32'h300, 0, 32'h44);
        #1;
        chk("rw.same_hit", 32'(pred_hit), 32'h0);
        chk("rw.same_target", pred_target, 32'h44);
        @(posedge clk);
        #1 set_upd(0, 0, 0, 0, 0, 0);
        #1;
        chk("rw.next_hit", 32'(pred_hit), 32'h1);
        chk("rw.next_target", pred_target, 32'h300);

        // statistics saturation, clear priority, then asynchronous reset
        for (int n = 0; n < 20; n++) begin
            set_upd(1, 32'h40, 1, 32'h100, 0, 32'h44);
            @(posedge clk);
            #1;
        end
        set_upd(0, 0, 0, 0, 0, 0);
        #1;
        chk("sat.ms", 32'(stat_mispredicts), 32'd15);
        chk("sat.br", 32'(stat_branches), 32'd15);
        stat_clear = 1;
        set_upd(1, 32'h40, 1, 32'h100, 0, 32'h44);
        @(posedge clk);
        #1 stat_clear = 0;
        set_upd(0, 0, 0, 0, 0, 0);
        #1;
        chk("clr.br", 32'(stat_branches), 32'd0);
        chk("clr.ms", 32'(stat_mispredicts), 32'd0);
        lookup_pc = 32'h40;
        set_upd(1, 32'h40, 1, 32'h100, 0, 32'h44);
        #1;
        chk("arst.pre_hit", 32'(pred_hit), 32'h1);
        rst_n = 0;
        #1;
        chk("arst.hit", 32'(pred_hit), 32'h0);
        chk("arst.br", 32'(stat_branches), 32'd0);
        @(posedge clk);
        #1;
        chk("arst.abort_hit", 32'(pred_hit), 32'h0);
        set_upd(0, 0, 0, 0, 0, 0);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc;
            lookup_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                      : (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
            pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
               : (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
            upd_valid = $urandom_range(0, 3) != 0;
            upd_pc = pc;
            upd_taken = $urandom_range(0, 1) == 1;
            upd_target = 32'($urandom_range(0, 7)) << 4;
            if ($urandom_range(0, 9) < 7) begin
                upd_pred_taken = m_hit(pc) && m_ctr[ix(pc)] >= 2;
                upd_pred_target = upd_pred_taken ? m_tgt[ix(pc)] : pc + 32'd4;
            end else begin
                upd_pred_taken = $urandom_range(0, 1) == 1;
                upd_pred_target = 32'($urandom_range(0, 7)) << 4;
            end
            stat_clear = $urandom_range(0, 31) == 0;
            #1;
            model_check($sformatf("r%0d", n));
            @(posedge clk);
            m_edge();
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters for the five-stage MIPS core.
- Lookup is combinational on the IF-stage PC and feeds the next-PC mux.
- Update comes from the ID-stage branch resolution.
- The block also produces the mispredict redirect and saturating branch/mispredict statistics counters.

Parameters:
- XLEN, 32, PC/target width in bits.
- ENTRIES, 16, BTB depth; power of two, >= 2; IDX_W = log2(ENTRIES).
- CTR_W, 2, direction counter width in bits; >= 1.
- STAT_W, 32, statistics counter width in bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lookup_pc  in  XLEN  IF-stage PC.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  predicted taken.
- pred_target  out  XLEN  predicted next PC.
- upd_valid  in  1  a branch resolved in ID this cycle.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  XLEN  actual taken target.
- upd_pred_taken  in  1  direction predicted for this branch at fetch.
- upd_pred_target  in  XLEN  next PC predicted for this branch at fetch.
- mispredict  out  1  prediction was wrong; redirect required.
- redirect_pc  out  XLEN  correct next PC.
- stat_clear  in  1  synchronous clear of the statistics counters.
- stat_branches  out  STAT_W  resolved-branch count.
- stat_mispredicts  out  STAT_W  mispredict count.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- On reset assertion, without waiting for a clock edge:
  - all valid bits = 0;
  - all counters = 2^(CTR_W-1)-1 (weakly not-taken);
  - both statistics counters = 0.
- Tag and target storage need not be reset.
- Addressing: PCs are word aligned; index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Lookup (combinational, zero latency):
  - pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && counter MSB.
  - pred_target = stored target if pred_taken, else lookup_pc+4 (mod 2^XLEN).
- Mispredict (combinational, same cycle as upd_valid):
  - mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4. It is meaningful only while mispredict=1.
- Update (rising edge, when upd_valid=1):
  - Hit, taken: counter += 1, saturating at 2^CTR_W-1; target = upd_target.
  - Hit, not taken: counter -= 1, saturating at 0; target unchanged.
  - Miss, taken: allocate (overwrite the aliasing entry): valid=1, tag, target, counter = 2^(CTR_W-1) (weakly taken).
  - Miss, not taken: no change.
- Read/write ordering: a lookup and an update to the same index in one cycle → the lookup sees pre-update contents; the new contents are visible from the next cycle.
- Statistics, per edge:
  - stat_clear=1 → both counters 0; clear has priority over increment.
  - Otherwise, upd_valid=1 → stat_branches+1; mispredict=1 → stat_mispredicts+1.
  - Both counters saturate at 2^STAT_W-1; no wrap.
- Reset asserted mid-operation aborts any pending update; no partial entry write.

Decomposition:
- Shared header BpredDefs.v: default values of XLEN, ENTRIES, CTR_W and STAT_W; the macro for the word-offset width (2).
- One sub-module, sat_counter: parametrised width, inc/dec/load, saturating. It is instantiated once per BTB entry.
- The statistics counters are inline saturating adders.

Test Plan (ENTRIES=16, CTR_W=2):
1. Release reset; lookup_pc=0x40 → pred_hit=0, pred_taken=0, pred_target=0x44; stats=0.
2. Update pc=0x40, taken, target=0x100, pred_taken=0:
   - same cycle → mispredict=1, redirect_pc=0x100;
   - next cycle, lookup 0x40 → hit=1, taken=1, target=0x100;
   - stat_branches=1, stat_mispredicts=1.
3. After test 2, two not-taken updates at 0x40:
   - after the first update → pred_taken=0 (counter 01);
   - after the second → counter 00, still hit;
   - a further not-taken update with upd_pred_taken=0 → mispredict=0, counter stays 00.
4. Aliasing: with 0x40 allocated, lookup 0x80 (same index 0) → pred_hit=0, pred_target=0x84. Then a taken update at 0x80 → target 0x200 → lookup 0x40 misses, lookup 0x80 hits.
5. Same-cycle update and lookup of 0x40 (taken, 0x300, from empty) → that cycle pred_hit=0; next cycle hit with 0x300.
6. With STAT_W=4: 20 mispredicting updates → stat_mispredicts holds 15. Then stat_clear together with upd_valid → both stats 0. Then drive rst_n low between edges → pred_hit=0 immediately.
